// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: three-port round-robin arbiter onto one memory bus with burst
// limiting and a tag FIFO that routes read acks back to the issuing port.
module mem_bus_arbiter #(
  parameter int BURST_LIMIT = 8,
  parameter int TAG_DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [2:0]  i_m_request,
  input  logic [2:0]  i_m_write,
  input  logic [11:0] i_m_bank,
  input  logic [71:0] i_m_address,
  input  logic [95:0] i_m_data,
  output logic [2:0]  o_m_busy,
  output logic [2:0]  o_m_ack,
  output logic [31:0] o_m_data,
  output logic        o_request,
  output logic        o_write,
  output logic [3:0]  o_bank,
  output logic [23:0] o_address,
  output logic [31:0] o_data,
  input  logic        i_busy,
  input  logic        i_ack,
  input  logic [31:0] i_data,
  output logic [1:0]  o_owner,
  output logic        o_owner_valid,
  output logic        o_ack_error
);
  localparam int PW = TAG_DEPTH > 1 ? $clog2(TAG_DEPTH) : 1;
  localparam logic [3:0] LIM = 4'(BURST_LIMIT - 1);
  localparam logic [PW:0] FULL = (PW + 1)'(TAG_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(TAG_DEPTH - 1);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state;
  logic [1:0] owner, rr, r1, r2, pick;
  logic [3:0] cnt;
  logic [1:0] tags [TAG_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] count;
  logic owner_req, full, accept, others, push, pop;
  always_comb begin
    r1 = rr == 2'd2 ? 2'd0 : rr + 2'd1;
    r2 = r1 == 2'd2 ? 2'd0 : r1 + 2'd1;
    pick = i_m_request[rr] ? rr : i_m_request[r1] ? r1 : r2;
    o_write = i_m_write[owner];
    o_bank = owner == 2'd2 ? i_m_bank[11:8] : owner == 2'd1 ? i_m_bank[7:4] : i_m_bank[3:0];
    o_address = owner == 2'd2 ? i_m_address[71:48] : owner == 2'd1 ? i_m_address[47:24] : i_m_address[23:0];
    o_data = owner == 2'd2 ? i_m_data[95:64] : owner == 2'd1 ? i_m_data[63:32] : i_m_data[31:0];
    owner_req = i_m_request[owner];
    full = count == FULL;
    o_request = state == OWN && owner_req && !(!o_write && full);
    accept = o_request && !i_busy;
    others = |(i_m_request & ~(3'b001 << owner));
    o_m_busy = accept ? ~(3'b001 << owner) : 3'b111;
    push = accept && !o_write;
    pop = i_ack && count != '0;
    o_m_ack = pop ? 3'b001 << tags[rp] : 3'b000;
    o_m_data = i_data;
    o_owner = owner;
    o_owner_valid = state == OWN;
  end
  // The counter saturates at the limit so a lone owner keeps streaming until a rival appears.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      owner <= 2'd0;
      rr <= 2'd0;
      cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (|i_m_request) begin
        owner <= pick;
        rr <= pick == 2'd2 ? 2'd0 : pick + 2'd1;
        cnt <= 4'd0;
        state <= OWN;
      end
    end else begin
      if (accept && cnt != LIM) cnt <= cnt + 4'd1;
      if (!owner_req || (accept && cnt == LIM && others)) state <= IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) tags[wp] <= owner;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      o_ack_error <= 1'b0;
    end else begin
      if (push) wp <= wp == LAST ? '0 : wp + 1'b1;
      if (pop) rp <= rp == LAST ? '0 : rp + 1'b1;
      count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
      if (i_ack && count == '0) o_ack_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios with a per-cycle behavioural model of
// ownership, burst limiting and tag routing, plus hand-computed spot checks.
module tb_mem_bus_arbiter;
  localparam int BL = 8;
  localparam int TD = 4;
  logic clk = 0;
  logic i_reset_n = 0;
  logic [2:0] i_m_request = 0, i_m_write = 0;
  logic [11:0] i_m_bank = {4'h3, 4'h2, 4'h1};
  logic [71:0] i_m_address = 0;
  logic [95:0] i_m_data = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  logic i_busy = 0, i_ack = 0;
  logic [31:0] i_data = 32'h12345678;
  logic [2:0] o_m_busy, o_m_ack;
  logic [31:0] o_m_data, o_data;
  logic o_request, o_write, o_owner_valid, o_ack_error;
  logic [3:0] o_bank;
  logic [23:0] o_address;
  logic [1:0] o_owner;
  int n_chk = 0, n_fail = 0;

  mem_bus_arbiter #(.BURST_LIMIT(BL), .TAG_DEPTH(TD)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_m_request(i_m_request), .i_m_write(i_m_write),
    .i_m_bank(i_m_bank), .i_m_address(i_m_address), .i_m_data(i_m_data),
    .o_m_busy(o_m_busy), .o_m_ack(o_m_ack), .o_m_data(o_m_data), .o_request(o_request),
    .o_write(o_write), .o_bank(o_bank), .o_address(o_address), .o_data(o_data),
    .i_busy(i_busy), .i_ack(i_ack), .i_data(i_data), .o_owner(o_owner),
    .o_owner_valid(o_owner_valid), .o_ack_error(o_ack_error));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: checks outputs at each negedge, then advances to the next edge.
  bit m_own, m_err;
  int m_owner, m_rr, m_cnt, p;
  int q[$];
  logic rd, e_req, acc, oth;
  logic [2:0] e_busy, e_ack;
  always @(negedge clk) begin
    if (!i_reset_n) begin
      m_own = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_err = 0; q.delete();
      chk("m_rst_req", o_request, 0);
      chk("m_rst_busy", o_m_busy, 3'b111);
      chk("m_rst_ack", o_m_ack, 0);
      chk("m_rst_valid", o_owner_valid, 0);
      chk("m_rst_owner", o_owner, 0);
      chk("m_rst_err", o_ack_error, 0);
    end else begin
      rd = !i_m_write[m_owner];
      e_req = m_own && i_m_request[m_owner] && !(rd && q.size() == TD);
      e_busy = 3'b111;
      if (m_own) e_busy[m_owner] = i_busy || !e_req;
      e_ack = (i_ack && q.size() > 0) ? 3'(1 << q[0]) : 3'b000;
      chk("m_req", o_request, e_req);
      chk("m_busy", o_m_busy, e_busy);
      chk("m_ack", o_m_ack, e_ack);
      chk("m_valid", o_owner_valid, m_own);
      chk("m_owner", o_owner, m_owner);
      chk("m_err", o_ack_error, m_err);
      chk("m_rdata", o_m_data, i_data);
      if (m_own) begin
        chk("m_write", o_write, i_m_write[m_owner]);
        chk("m_bank", o_bank, i_m_bank[m_owner*4 +: 4]);
        chk("m_addr", o_address, i_m_address[m_owner*24 +: 24]);
        chk("m_data", o_data, i_m_data[m_owner*32 +: 32]);
      end
      if (i_ack) begin
        if (q.size() > 0) void'(q.pop_front()); else m_err = 1;
      end
      if (m_own) begin
        acc = e_req && !i_busy;
        oth = |(i_m_request & ~(3'b001 << m_owner));
        if (acc && rd) q.push_back(m_owner);
        if (!i_m_request[m_owner]) m_own = 0;
        else if (acc) begin
          if (m_cnt + 1 < BL) m_cnt++;
          else if (oth) m_own = 0;
        end
      end else if (|i_m_request) begin
        p = m_rr;
        while (!i_m_request[p]) p = (p + 1) % 3;
        m_owner = p; m_rr = (p + 1) % 3; m_cnt = 0; m_own = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    i_reset_n = 0; i_m_request = 0; i_m_write = 0; i_busy = 0; i_ack = 0;
    @(negedge clk);
    step();
    i_reset_n = 1;
  endtask

  int own_log[$], cnt_log[$];
  int idle_n, acc_n;

  initial begin
    @(negedge clk);
    chk("rst_busy", o_m_busy, 3'b111);
    chk("rst_valid", o_owner_valid, 0);
    step();
    i_reset_n = 1;
    // Port 1 writes three words.
    i_m_request = 3'b010; i_m_write = 3'b010; i_m_address[47:24] = 24'h000100;
    @(negedge clk);
    chk("w3_idle_req", o_request, 0);
    chk("w3_idle_busy", o_m_busy, 3'b111);
    step();
    for (int k = 0; k < 3; k++) begin
      i_m_address[47:24] = 24'h000100 + 24'(k);
      @(negedge clk);
      chk("w3_req", o_request, 1);
      chk("w3_addr", o_address, 24'h000100 + 24'(k));
      chk("w3_busy", o_m_busy, 3'b101);
      step();
    end
    i_m_request = 0;
    @(negedge clk);
    chk("w3_drop_req", o_request, 0);
    chk("w3_drop_valid", o_owner_valid, 1);
    step();
    @(negedge clk);
    chk("w3_idle_after", o_owner_valid, 0);
    step();
    // All three ports stream writes.
    do_reset();
    i_m_request = 3'b111; i_m_write = 3'b111; idle_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k < 36 && !o_owner_valid) idle_n++;
      if (o_request && !i_busy) begin
        if (own_log.size() == 0 || own_log[$] != int'(o_owner)) begin
          own_log.push_back(int'(o_owner)); cnt_log.push_back(1);
        end else cnt_log[$] = cnt_log[$] + 1;
      end
      step();
    end
    chk("rr_groups", (own_log.size() >= 4) ? 1 : 0, 1);
    if (own_log.size() >= 4) begin
      chk("rr_own0", own_log[0], 0); chk("rr_own1", own_log[1], 1);
      chk("rr_own2", own_log[2], 2); chk("rr_own3", own_log[3], 0);
      chk("rr_cnt0", cnt_log[0], 8); chk("rr_cnt1", cnt_log[1], 8);
      chk("rr_cnt2", cnt_log[2], 8);
    end
    chk("rr_idle_cycles", idle_n, 4);
    // Port 2 reads until the tag FIFO fills.
    do_reset();
    i_m_request = 3'b100; i_m_write = 3'b000;
    @(negedge clk); step();
    for (int k = 0; k < 4; k++) begin
      i_m_address[71:48] = 24'h200 + 24'(k);
      @(negedge clk);
      chk("full_acc", o_request, 1);
      step();
    end
    @(negedge clk);
    chk("full_req", o_request, 0);
    chk("full_busy", o_m_busy, 3'b111);
    step();
    i_ack = 1; i_data = 32'hDEAD0001;
    @(negedge clk);
    chk("full_ack", o_m_ack, 3'b100);
    step();
    i_ack = 0;
    @(negedge clk);
    chk("full_5th", o_request, 1);
    chk("full_5th_busy", o_m_busy, 3'b011);
    step();
    i_m_request = 0;
    // Acks for port 0 arrive while port 1 owns the bus.
    do_reset();
    i_m_request = 3'b001;
    @(negedge clk); step();
    @(negedge clk); step();
    @(negedge clk); step();
    i_m_request = 3'b010; i_m_write = 3'b010;
    @(negedge clk); step();
    @(negedge clk); step();
    i_ack = 1; i_data = 32'hA5A50001;
    @(negedge clk);
    chk("route_owner", o_owner, 1);
    chk("route_ack1", o_m_ack, 3'b001);
    chk("route_data1", o_m_data, 32'hA5A50001);
    step();
    i_data = 32'hA5A50002;
    @(negedge clk);
    chk("route_ack2", o_m_ack, 3'b001);
    chk("route_data2", o_m_data, 32'hA5A50002);
    step();
    i_ack = 0; i_m_request = 0;
    @(negedge clk);
    chk("route_no_err", o_ack_error, 0);
    step();
    // Stray ack with an empty FIFO.
    i_ack = 1;
    @(negedge clk);
    chk("stray_ack", o_m_ack, 0);
    step();
    i_ack = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stray_err", o_ack_error, 1);
      step();
    end
    // Burst saturates while alone, then yields once port 1 asks.
    do_reset();
    i_m_request = 3'b001; i_m_write = 3'b001; acc_n = 0;
    for (int k = 0; k < 13; k++) begin
      if (k == 12) i_m_request = 3'b011;
      @(negedge clk);
      if (o_request && !i_busy && o_owner == 2'd0) acc_n++;
      step();
    end
    chk("sat_accepts", acc_n, 12);
    @(negedge clk);
    chk("sat_release", o_owner_valid, 0);
    step();
    @(negedge clk);
    chk("sat_next_owner", o_owner, 1);
    step();
    // Reset mid-transfer with two tags pending.
    do_reset();
    i_m_request = 3'b001; i_m_write = 3'b000;
    @(negedge clk); step();
    @(negedge clk); step();
    @(negedge clk); step();
    i_busy = 1;
    @(negedge clk);
    #1 i_reset_n = 0;
    #1;
    chk("mid_rst_req", o_request, 0);
    chk("mid_rst_busy", o_m_busy, 3'b111);
    chk("mid_rst_valid", o_owner_valid, 0);
    @(negedge clk);
    step();
    i_reset_n = 1; i_m_request = 0; i_busy = 0; i_ack = 1;
    @(negedge clk);
    chk("mid_rst_ack", o_m_ack, 0);
    step();
    i_ack = 0;
    @(negedge clk);
    chk("mid_rst_err", o_ack_error, 1);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
